// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, shift right/left, parallel load.
// Counts shifts since the last load and pulses done when cnt first reaches WIDTH. Optional rotate via ROTATE_EN.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_en,
  input  logic [1:0]                       i_mode,
  input  logic                             i_sin_r,
  input  logic                             i_sin_l,
`ifdef ROTATE_EN
  input  logic                             i_rot,
`endif
  input  logic [WIDTH-1:0]                 i_pin,
  output logic [WIDTH-1:0]                 o_q,
  output logic                             o_sout_r,
  output logic                             o_sout_l,
  output logic [$clog2(WIDTH+1)-1:0]       o_cnt,
  output logic                             o_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHR   = 2'b01,
    MODE_SHL   = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic             w_fill_r;
  logic             w_fill_l;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done_nxt;
  mode_e            w_mode;

  // A rotate recirculates the bit leaving the far end instead of taking serial input.
`ifdef ROTATE_EN
  assign w_fill_r = i_rot ? r_q[0]       : i_sin_r;
  assign w_fill_l = i_rot ? r_q[WIDTH-1] : i_sin_l;
`else
  assign w_fill_r = i_sin_r;
  assign w_fill_l = i_sin_l;
`endif

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shr = w_fill_r;
      assign w_shl = w_fill_l;
    end else begin : g_wn
      assign w_shr = {w_fill_r, r_q[WIDTH-1:1]};
      assign w_shl = {r_q[WIDTH-2:0], w_fill_l};
    end
  endgenerate

  assign w_mode = mode_e'(i_mode);

  // Next-state: shifts advance a saturating count; done marks the WIDTH-1 -> WIDTH step only.
  always_comb begin
    w_q_nxt    = r_q;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    if (i_en) begin
      case (w_mode)
        MODE_SHR, MODE_SHL: begin
          w_q_nxt    = (w_mode == MODE_SHR) ? w_shr : w_shl;
          w_cnt_nxt  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
          w_done_nxt = (r_cnt == CNT_MAX - CNT_ONE);
        end
        MODE_LOAD: begin
          w_q_nxt   = i_pin;
          w_cnt_nxt = '0;
        end
        default: begin
          w_q_nxt   = r_q;
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign o_q      = r_q;
  assign o_sout_r = r_q[0];
  assign o_sout_l = r_q[WIDTH-1];
  assign o_cnt    = r_cnt;
  assign o_done   = r_done;

endmodule
